// File: rtl/ads7056_pkg.sv
// Shared types and frame-layout constants for the ADS7056 sequencer.
// The conversion frame is LEAD_BITS zeros, DATA_WIDTH result bits MSB first, then TRAIL_BITS ignored bits.
package ads7056_pkg;

  localparam int DATA_WIDTH = 14;
  localparam int LEAD_BITS  = 2;
  localparam int TRAIL_BITS = 2;
  localparam int FRAME_BITS = LEAD_BITS + DATA_WIDTH + TRAIL_BITS;

  // Width of an SCLK count and of a frame cycle index (2N needs one extra bit).
  localparam int SCLK_W  = 8;
  localparam int CYCLE_W = SCLK_W + 1;

  typedef enum logic [2:0] {
    ST_DUMMY_START,
    ST_DUMMY,
    ST_QUIET_D,
    ST_CAL,
    ST_QUIET_C,
    ST_IDLE,
    ST_CONV,
    ST_QUIET_V
  } seqState_t;

endpackage

// File: rtl/ads7056_frame.sv
// One chip-select window carrying N SCLK pulses at ipClk/2.
// nCs is low for 2N+1 cycles; rise/done are combinational strobes for the edge that raises SCLK / ends the frame.
module ads7056_frame
  import ads7056_pkg::*;
(
  input  logic              ipClk,
  input  logic              ipnReset,
  input  logic              start,
  input  logic [SCLK_W-1:0] numSclks,
  output logic              nCs,
  output logic              sClk,
  output logic              rise,
  output logic              done
);

  logic [CYCLE_W-1:0] cycleCnt;
  logic [CYCLE_W-1:0] lastCycle;
  logic               active;

  always_ff @(posedge ipClk or negedge ipnReset) begin
    if (!ipnReset) begin
      nCs       <= 1'b1;
      sClk      <= 1'b0;
      active    <= 1'b0;
      cycleCnt  <= '0;
      lastCycle <= '0;
    end else if (active) begin
      if (done) begin
        nCs      <= 1'b1;
        sClk     <= 1'b0;
        active   <= 1'b0;
        cycleCnt <= '0;
      end else begin
        sClk     <= ~sClk;
        cycleCnt <= cycleCnt + 1'b1;
      end
    end else if (start) begin
      // Count is latched so the caller may change numSclks once the frame is running.
      nCs       <= 1'b0;
      active    <= 1'b1;
      cycleCnt  <= '0;
      lastCycle <= {numSclks, 1'b0};
    end
  end

  assign rise = active && !sClk && (cycleCnt < lastCycle);
  assign done = active && (cycleCnt == lastCycle);

endmodule

// File: rtl/ads7056_sequencer.sv
// Owns the ADS7056 pins: power-up dummy frame, offset calibration, then free-run or
// single-shot conversions with on-demand recalibration and overrun reporting.
module ads7056_sequencer
  import ads7056_pkg::*;
#(
  parameter int PERIOD      = 64,
  parameter int QUIET       = 4,
  parameter int DUMMY_SCLKS = 24,
  parameter int CAL_SCLKS   = 64,
  parameter int CONV_SCLKS  = 18
) (
  input  logic                  ipClk,
  input  logic                  ipnReset,
  input  logic                  ipEnable,
  input  logic                  ipTrigger,
  input  logic                  ipCalibrate,
  output logic                  opSClk,
  output logic                  opnCS,
  input  logic                  ipData,
  output logic [DATA_WIDTH-1:0] opData,
  output logic                  opValid,
  output logic                  opReady,
  output logic                  opOverrun
);

  localparam int PERIOD_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int QUIET_W  = 8;
  localparam logic [PERIOD_W-1:0] PERIOD_LAST  = PERIOD_W'(PERIOD - 1);
  localparam logic [QUIET_W-1:0]  QUIET_D_LAST = QUIET_W'((QUIET >= 1) ? QUIET - 1 : 0);
  // After a conversion the IDLE decision cycle doubles as the final quiet cycle,
  // so back-to-back conversions fit in 2*CONV_SCLKS+1+QUIET cycles.
  localparam logic [QUIET_W-1:0]  QUIET_V_LAST = QUIET_W'((QUIET >= 2) ? QUIET - 2 : 0);

  seqState_t              state;
  logic [QUIET_W-1:0]     quietCnt;
  logic [PERIOD_W-1:0]    periodCnt;
  logic                   calibrated;
  logic                   pendingCal;
  logic [FRAME_BITS-1:0]  shiftReg;
  logic [DATA_WIDTH-1:0]  dataReg;
  logic                   validReg;
  logic                   readyReg;
  logic                   overrunReg;

  logic                   frameStart;
  logic [SCLK_W-1:0]      frameSclks;
  logic                   frameRise;
  logic                   frameDone;
  logic                   calEntry;
  logic                   tick;
  logic                   request;

  assign tick    = ipEnable && calibrated && (periodCnt == PERIOD_LAST);
  assign request = tick || ipTrigger;

  always_comb begin
    frameStart = 1'b0;
    frameSclks = SCLK_W'(CONV_SCLKS);
    calEntry   = 1'b0;
    case (state)
      ST_DUMMY_START: begin
        frameStart = 1'b1;
        frameSclks = SCLK_W'(DUMMY_SCLKS);
      end
      ST_QUIET_D: begin
        if (quietCnt == QUIET_D_LAST) begin
          frameStart = 1'b1;
          frameSclks = SCLK_W'(CAL_SCLKS);
          calEntry   = 1'b1;
        end
      end
      ST_IDLE: begin
        if (pendingCal) begin
          frameStart = 1'b1;
          frameSclks = SCLK_W'(CAL_SCLKS);
          calEntry   = 1'b1;
        end else if (request) begin
          frameStart = 1'b1;
          frameSclks = SCLK_W'(CONV_SCLKS);
        end
      end
      default: ;
    endcase
  end

  ads7056_frame uFrame (
    .ipClk    (ipClk),
    .ipnReset (ipnReset),
    .start    (frameStart),
    .numSclks (frameSclks),
    .nCs      (opnCS),
    .sClk     (opSClk),
    .rise     (frameRise),
    .done     (frameDone)
  );

  always_ff @(posedge ipClk or negedge ipnReset) begin
    if (!ipnReset) begin
      state      <= ST_DUMMY_START;
      quietCnt   <= '0;
      periodCnt  <= '0;
      calibrated <= 1'b0;
      pendingCal <= 1'b0;
      shiftReg   <= '0;
      dataReg    <= '0;
      validReg   <= 1'b0;
      readyReg   <= 1'b0;
      overrunReg <= 1'b0;
    end else begin
      validReg <= 1'b0;

      // A request is dropped unless it launches a conversion from IDLE.
      if (state != ST_IDLE) begin
        overrunReg <= request;
      end else begin
        overrunReg <= pendingCal && request;
      end

      if (!ipEnable) begin
        periodCnt <= '0;
      end else if (calibrated) begin
        periodCnt <= tick ? '0 : periodCnt + 1'b1;
      end

      pendingCal <= ipCalibrate || (pendingCal && !calEntry);

      if (state == ST_CONV && frameRise) begin
        shiftReg <= {shiftReg[FRAME_BITS-2:0], ipData};
      end

      case (state)
        ST_DUMMY_START: begin
          state <= ST_DUMMY;
        end
        ST_DUMMY: begin
          if (frameDone) begin
            state    <= ST_QUIET_D;
            quietCnt <= '0;
          end
        end
        ST_QUIET_D: begin
          if (calEntry) begin
            state <= ST_CAL;
          end else begin
            quietCnt <= quietCnt + 1'b1;
          end
        end
        ST_CAL: begin
          if (frameDone) begin
            state    <= ST_QUIET_C;
            quietCnt <= '0;
          end
        end
        ST_QUIET_C: begin
          if (quietCnt == QUIET_D_LAST) begin
            state      <= ST_IDLE;
            readyReg   <= 1'b1;
            calibrated <= 1'b1;
          end else begin
            quietCnt <= quietCnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (calEntry) begin
            state    <= ST_CAL;
            readyReg <= 1'b0;
          end else if (frameStart) begin
            state    <= ST_CONV;
            readyReg <= 1'b0;
          end
        end
        ST_CONV: begin
          if (frameDone) begin
            state    <= ST_QUIET_V;
            quietCnt <= '0;
            validReg <= 1'b1;
            dataReg  <= shiftReg[TRAIL_BITS +: DATA_WIDTH];
          end
        end
        ST_QUIET_V: begin
          if (quietCnt == QUIET_V_LAST) begin
            state    <= ST_IDLE;
            readyReg <= 1'b1;
          end else begin
            quietCnt <= quietCnt + 1'b1;
          end
        end
        default: begin
          state <= ST_DUMMY_START;
        end
      endcase
    end
  end

  assign opData    = dataReg;
  assign opValid   = validReg;
  assign opReady   = readyReg;
  assign opOverrun = overrunReg;

endmodule
